// File: rtl/arm_regfile.sv
// 32 x DATA_W register file, two registered read ports, one write port.
// Define REGFILE_XZR_EN to make r31 the zero register.
module arm_regfile #(
    parameter int DATA_W = 64,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [4:0]        read_register1,
    input  logic [4:0]        read_register2,
    input  logic [4:0]        write_register,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2
);

    localparam int AW = 5;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [DATA_W-1:0] regs_d [NREGS];
    logic [DATA_W-1:0] read_data1_q, read_data1_d;
    logic [DATA_W-1:0] read_data2_q, read_data2_d;
    logic              wr_en;

    function automatic logic [DATA_W-1:0] preload(input logic [AW-1:0] idx);
        logic [DATA_W-1:0] v;
        case (idx)
            5'd0:    v = DATA_W'(256);
            5'd3:    v = DATA_W'(16);
            5'd5:    v = DATA_W'(4);
            5'd12:   v = DATA_W'(17);
            5'd15:   v = DATA_W'(129);
            5'd19:   v = DATA_W'(10);
            default: v = '0;
        endcase
        return v;
    endfunction

    // Reads sample regs_q, so a same-edge write is never bypassed.
    always_comb begin
        regs_d = regs_q;
`ifdef REGFILE_XZR_EN
        wr_en        = reg_write && (write_register != 5'd31);
        read_data1_d = (read_register1 == 5'd31) ? '0 : regs_q[read_register1];
        read_data2_d = (read_register2 == 5'd31) ? '0 : regs_q[read_register2];
`else
        wr_en        = reg_write;
        read_data1_d = regs_q[read_register1];
        read_data2_d = regs_q[read_register2];
`endif
        if (wr_en) begin
            regs_d[write_register] = write_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= preload(AW'(i));
            end
            read_data1_q <= '0;
            read_data2_q <= '0;
        end else begin
            regs_q       <= regs_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
        end
    end

    assign read_data1 = read_data1_q;
    assign read_data2 = read_data2_q;

endmodule

// File: tb/tb_arm_regfile.sv
// Scoreboard bench for arm_regfile; honours REGFILE_XZR_EN.
module tb_arm_regfile;

    localparam int W = 64;
`ifdef REGFILE_XZR_EN
    localparam bit XZR = 1'b1;
`else
    localparam bit XZR = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   read_register1 = '0;
    logic [4:0]   read_register2 = '0;
    logic [4:0]   write_register = '0;
    logic [W-1:0] write_data = '0;
    logic         reg_write = 1'b0;
    logic [W-1:0] read_data1;
    logic [W-1:0] read_data2;

    logic [W-1:0] model [32];
    logic [W-1:0] q1 [$];
    logic [W-1:0] q2 [$];
    logic [W-1:0] e1, e2;
    int total = 0;
    int bad = 0;

    arm_regfile #(.DATA_W(W), .NREGS(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .read_register1(read_register1),
        .read_register2(read_register2),
        .write_register(write_register),
        .write_data(write_data),
        .reg_write(reg_write),
        .read_data1(read_data1),
        .read_data2(read_data2)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] pre(input int i);
        case (i)
            0:       return 64'd256;
            3:       return 64'd16;
            5:       return 64'd4;
            12:      return 64'd17;
            15:      return 64'd129;
            19:      return 64'd10;
            default: return 64'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = pre(i);
        q1.delete();
        q2.delete();
    endtask

    // Drive one cycle of stimulus and push the expected read results.
    task automatic drive(input logic [4:0] a1, input logic [4:0] a2,
                         input logic [4:0] aw, input logic [W-1:0] wd,
                         input logic we);
        read_register1 = a1;
        read_register2 = a2;
        write_register = aw;
        write_data     = wd;
        reg_write      = we;
        q1.push_back((XZR && a1 == 5'd31) ? '0 : model[a1]);
        q2.push_back((XZR && a2 == 5'd31) ? '0 : model[a2]);
        if (we && !(XZR && aw == 5'd31)) model[aw] = wd;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        total += 2;
        if (read_data1 !== '0) begin
            bad++; $display("FAIL reset_rd1 got=%h want=0", read_data1);
        end
        if (read_data2 !== '0) begin
            bad++; $display("FAIL reset_rd2 got=%h want=0", read_data2);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
    endtask

    task automatic test_preload();
        logic [4:0] t1 [3] = '{5'd0, 5'd3, 5'd15};
        logic [4:0] t2 [3] = '{5'd5, 5'd19, 5'd12};
        logic [W-1:0] x1 [3] = '{64'd256, 64'd16, 64'd129};
        logic [W-1:0] x2 [3] = '{64'd4, 64'd10, 64'd17};
        for (int i = 0; i < 3; i++) begin
            drive(t1[i], t2[i], 5'd0, 64'd0, 1'b0);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== x1[i] || e1 !== x1[i]) begin
                bad++; $display("FAIL preload_rd1 r%0d got=%0d want=%0d", t1[i], read_data1, x1[i]);
            end
            if (read_data2 !== x2[i] || e2 !== x2[i]) begin
                bad++; $display("FAIL preload_rd2 r%0d got=%0d want=%0d", t2[i], read_data2, x2[i]);
            end
        end
        for (int i = 0; i < 32; i++) begin
            drive(5'(i), 5'(31 - i), 5'd0, 64'd0, 1'b0);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== e1) begin
                bad++; $display("FAIL preload_all_rd1 r%0d got=%h want=%h", i, read_data1, e1);
            end
            if (read_data2 !== e2) begin
                bad++; $display("FAIL preload_all_rd2 r%0d got=%h want=%h", 31 - i, read_data2, e2);
            end
        end
    endtask

    task automatic test_write_old_new();
        logic [W-1:0] x1 [2] = '{64'd256, 64'd55};
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd15, 5'd0, 64'd55, 1'b1);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== x1[i] || e1 !== x1[i]) begin
                bad++; $display("FAIL write_old_new_rd1 edge%0d got=%0d want=%0d", i, read_data1, x1[i]);
            end
            if (read_data2 !== 64'd129) begin
                bad++; $display("FAIL write_old_new_rd2 edge%0d got=%0d want=129", i, read_data2);
            end
        end
    endtask

    task automatic test_negative();
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd15, 5'd15, -64'sd354, 1'b1);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== e1) begin
                bad++; $display("FAIL negative_rd1 edge%0d got=%h want=%h", i, read_data1, e1);
            end
            if (read_data2 !== e2) begin
                bad++; $display("FAIL negative_rd2 edge%0d got=%h want=%h", i, read_data2, e2);
            end
        end
        total++;
        if (read_data2 !== 64'hFFFF_FFFF_FFFF_FE9E) begin
            bad++; $display("FAIL negative_value got=%h want=fffffffffffffe9e", read_data2);
        end
    endtask

    task automatic test_no_write();
        for (int i = 0; i < 2; i++) begin
            drive(5'd0, 5'd15, 5'(i * 15), 64'd23456, 1'b0);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== e1 || e1 !== 64'd55) begin
                bad++; $display("FAIL no_write_rd1 got=%0d want=55", read_data1);
            end
            if (read_data2 !== e2) begin
                bad++; $display("FAIL no_write_rd2 got=%h want=%h", read_data2, e2);
            end
        end
        drive(5'd15, 5'd15, 5'd0, 64'd23456, 1'b0);
        #2;
        total++;
        if (read_data1 !== 64'd55) begin
            bad++; $display("FAIL hold_rd1 got=%0d want=55", read_data1);
        end
        @(posedge clk); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        total += 2;
        if (read_data1 !== e1) begin
            bad++; $display("FAIL latency_rd1 got=%h want=%h", read_data1, e1);
        end
        if (read_data2 !== e2) begin
            bad++; $display("FAIL same_addr_rd2 got=%h want=%h", read_data2, e2);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 31; i++) begin
            drive(5'(i), 5'((i + 30) % 31), 5'(i), {$urandom, $urandom}, 1'b1);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== e1) begin
                bad++; $display("FAIL b2b_rd1 r%0d got=%h want=%h", i, read_data1, e1);
            end
            if (read_data2 !== e2) begin
                bad++; $display("FAIL b2b_rd2 r%0d got=%h want=%h", (i + 30) % 31, read_data2, e2);
            end
        end
        reg_write = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [4:0] t1 [2] = '{5'd0, 5'd3};
        logic [4:0] t2 [2] = '{5'd15, 5'd5};
        logic [W-1:0] x1 [2] = '{64'd256, 64'd16};
        logic [W-1:0] x2 [2] = '{64'd129, 64'd4};
        #2;
        rst_n = 1'b0;
        #1;
        total += 2;
        if (read_data1 !== '0) begin
            bad++; $display("FAIL async_rst_rd1 got=%h want=0", read_data1);
        end
        if (read_data2 !== '0) begin
            bad++; $display("FAIL async_rst_rd2 got=%h want=0", read_data2);
        end
        read_register1 = 5'd3;
        write_register = 5'd3;
        write_data     = 64'd999;
        reg_write      = 1'b1;
        @(posedge clk); #2;
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            drive(t1[i], t2[i], 5'd0, 64'd0, 1'b0);
            @(posedge clk); #1;
            e1 = q1.pop_front(); e2 = q2.pop_front();
            total += 2;
            if (read_data1 !== x1[i] || e1 !== x1[i]) begin
                bad++; $display("FAIL post_rst_rd1 r%0d got=%0d want=%0d", t1[i], read_data1, x1[i]);
            end
            if (read_data2 !== x2[i] || e2 !== x2[i]) begin
                bad++; $display("FAIL post_rst_rd2 r%0d got=%0d want=%0d", t2[i], read_data2, x2[i]);
            end
        end
    endtask

    task automatic test_xzr();
        logic [W-1:0] want;
        want = XZR ? 64'd0 : 64'd7;
        drive(5'd0, 5'd0, 5'd31, 64'd7, 1'b1);
        @(posedge clk); #1;
        void'(q1.pop_front()); void'(q2.pop_front());
        drive(5'd31, 5'd31, 5'd0, 64'd0, 1'b0);
        @(posedge clk); #1;
        e1 = q1.pop_front(); e2 = q2.pop_front();
        total += 2;
        if (read_data1 !== want || e1 !== want) begin
            bad++; $display("FAIL xzr_rd1 got=%0d want=%0d", read_data1, want);
        end
        if (read_data2 !== want || e2 !== want) begin
            bad++; $display("FAIL xzr_rd2 got=%0d want=%0d", read_data2, want);
        end
    endtask

    initial begin
        test_reset();
        test_preload();
        test_write_old_new();
        test_negative();
        test_no_write();
        test_back_to_back();
        test_async_reset();
        test_xzr();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
